// File: rtl/block_refill_mem.sv
// Backing memory for the data cache: 64-bit block refills over eight byte beats and byte write-through stores.
// Define BLOCK_REFILL_WBUF_EN to enable a one-entry posted write buffer that drains in the background.
module block_refill_mem #(
    parameter int ADDR_W  = 16,
    parameter int LATENCY = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_req,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        data_in,
    output logic [63:0]       block_out,
    output logic              ready,
    output logic              busy
);
    typedef enum logic [2:0] {IDLE, WAIT, BURST, WCOMMIT, DONE} state_t;

    localparam int         BLK_W  = ADDR_W - 3;
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    state_t           state_q, state_d;
    logic [3:0]       lat_q, lat_d;
    logic [2:0]       beat_q, beat_d;
    logic [BLK_W-1:0] blk_q, blk_d;
    logic [55:0]      asm_q, asm_d;
    logic [63:0]      out_q, out_d;

    logic [7:0]        mem [0:(1<<ADDR_W)-1];
    logic [7:0]        mem_rd;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [7:0]        mem_wdata;

`ifdef BLOCK_REFILL_WBUF_EN
    logic              wb_vld_q, wb_vld_d;
    logic [3:0]        drain_q, drain_d;
    logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
    logic [7:0]        wb_data_q, wb_data_d;
`else
    logic              is_wr_q, is_wr_d;
    logic [2:0]        off_q, off_d;
    logic [7:0]        data_q, data_d;
`endif

    assign mem_rd = mem[{blk_q, beat_q}];

    always_comb begin
        state_d   = state_q;
        lat_d     = lat_q;
        beat_d    = beat_q;
        blk_d     = blk_q;
        asm_d     = asm_q;
        out_d     = out_q;
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
`ifdef BLOCK_REFILL_WBUF_EN
        wb_vld_d  = wb_vld_q;
        drain_d   = drain_q;
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
        // Drain timer mirrors the unbuffered WAIT+WCOMMIT timing: commit lands in cycle LATENCY+1.
        if (wb_vld_q) begin
            if (drain_q == '0) begin
                mem_we    = 1'b1;
                mem_waddr = wb_addr_q;
                mem_wdata = wb_data_q;
                wb_vld_d  = 1'b0;
            end else begin
                drain_d = drain_q - 4'd1;
            end
        end
`else
        is_wr_d   = is_wr_q;
        off_d     = off_q;
        data_d    = data_q;
`endif

        case (state_q)
            IDLE: begin
`ifdef BLOCK_REFILL_WBUF_EN
                if (wr_req && !wb_vld_q) begin
                    wb_vld_d  = 1'b1;
                    drain_d   = 4'(LATENCY);
                    wb_addr_d = addr;
                    wb_data_d = data_in;
                    state_d   = DONE;
                end else if (rd_req && !wr_req) begin
                    blk_d   = addr[ADDR_W-1:3];
                    lat_d   = LAT_M1;
                    state_d = WAIT;
                end
`else
                if (wr_req) begin
                    is_wr_d = 1'b1;
                    blk_d   = addr[ADDR_W-1:3];
                    off_d   = addr[2:0];
                    data_d  = data_in;
                    lat_d   = LAT_M1;
                    state_d = WAIT;
                end else if (rd_req) begin
                    is_wr_d = 1'b0;
                    blk_d   = addr[ADDR_W-1:3];
                    lat_d   = LAT_M1;
                    state_d = WAIT;
                end
`endif
            end
            WAIT: begin
`ifdef BLOCK_REFILL_WBUF_EN
                // A pending drain holds the read's latency count so the burst sees the stored byte.
                if (wb_vld_q) begin
                    lat_d = LAT_M1;
                end else if (lat_q == '0) begin
                    state_d = BURST;
                end else begin
                    lat_d = lat_q - 4'd1;
                end
`else
                if (lat_q == '0) begin
                    state_d = is_wr_q ? WCOMMIT : BURST;
                end else begin
                    lat_d = lat_q - 4'd1;
                end
`endif
            end
            BURST: begin
                beat_d = beat_q + 3'd1;
                if (beat_q == 3'd7) begin
                    out_d   = {mem_rd, asm_q};
                    state_d = DONE;
                end else begin
                    asm_d[{beat_q, 3'b000} +: 8] = mem_rd;
                end
            end
`ifndef BLOCK_REFILL_WBUF_EN
            WCOMMIT: begin
                mem_we    = 1'b1;
                mem_waddr = {blk_q, off_q};
                mem_wdata = data_q;
                state_d   = DONE;
            end
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            lat_q     <= '0;
            beat_q    <= '0;
            blk_q     <= '0;
            asm_q     <= '0;
            out_q     <= '0;
`ifdef BLOCK_REFILL_WBUF_EN
            wb_vld_q  <= 1'b0;
            drain_q   <= '0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
`else
            is_wr_q   <= 1'b0;
            off_q     <= '0;
            data_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            lat_q     <= lat_d;
            beat_q    <= beat_d;
            blk_q     <= blk_d;
            asm_q     <= asm_d;
            out_q     <= out_d;
`ifdef BLOCK_REFILL_WBUF_EN
            wb_vld_q  <= wb_vld_d;
            drain_q   <= drain_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
`else
            is_wr_q   <= is_wr_d;
            off_q     <= off_d;
            data_q    <= data_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign block_out = out_q;
    assign ready     = (state_q == DONE);
`ifdef BLOCK_REFILL_WBUF_EN
    assign busy      = (state_q != IDLE) || wb_vld_q;
`else
    assign busy      = (state_q != IDLE);
`endif

endmodule
